// File: rtl/key_schedule_gen.sv
// key_schedule_gen: AES-128/192/256 key expansion, one word per cycle, with registered round-key readout.
module key_schedule_gen #(
  parameter int SUPPORT_192 = 1,
  parameter int SUPPORT_256 = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         rk_valid,
  input  logic [3:0]   rk_round,
  output logic [127:0] rk_out
);
  localparam int NW = SUPPORT_256 != 0 ? 60 : 52;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] w_q [NW];
  logic [31:0] w_d [NW];
  logic [5:0] i_q, i_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] nk_q, nk_d, nr_q, nr_d, nk_new, nr_new;
  logic [7:0] rcon_q, rcon_d;
  logic err_q, err_d, rk_valid_q, rk_valid_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic supported, accept, last;
  logic [31:0] prev, back, sb_in, sb_out, t;
  assign supported = key_len == 2'd0 || (key_len == 2'd1 && SUPPORT_192 != 0) ||
                     (key_len == 2'd2 && SUPPORT_256 != 0);
  assign accept = state_q == IDLE && start && supported;
  assign nk_new = key_len == 2'd1 ? 4'd6 : key_len == 2'd2 ? 4'd8 : 4'd4;
  assign nr_new = nk_new + 4'd6;
  assign last = i_q == {nr_q, 2'b11};
  assign prev = w_q[i_q - 6'd1];
  assign back = w_q[i_q - {2'b00, nk_q}];
  // cnt_q tracks i mod Nk so no divider is needed
  assign sb_in = cnt_q == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
  assign t = cnt_q == 3'd0 ? sb_out ^ {rcon_q, 24'h0} :
             (nk_q == 4'd8 && cnt_q == 3'd4) ? sb_out : prev;
  genvar g;
  for (g = 0; g < 4; g++) begin : g_sbox
    Sbox u_sbox (.in_byte(sb_in[8*g +: 8]), .out_byte(sb_out[8*g +: 8]));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (accept ? EXPAND : IDLE) :
              state_q == EXPAND ? (last ? DONE : EXPAND) : IDLE;
  end
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
  end
  always_comb begin
    w_d = w_q;
    i_d = i_q;
    cnt_d = cnt_q;
    nk_d = nk_q;
    nr_d = nr_q;
    rcon_d = rcon_q;
    err_d = state_q == IDLE && start && !supported;
    rk_valid_d = err_d ? 1'b0 : rk_valid_q;
    if (accept) begin
      for (int j = 0; j < 8; j++)
        if (j < int'(nk_new)) w_d[j] = key[255 - 32*j -: 32];
      i_d = {2'b00, nk_new};
      cnt_d = 3'd0;
      nk_d = nk_new;
      nr_d = nr_new;
      rcon_d = 8'h01;
      rk_valid_d = 1'b0;
    end
    if (state_q == EXPAND) begin
      w_d[i_q] = back ^ t;
      i_d = i_q + 6'd1;
      cnt_d = {1'b0, cnt_q} == nk_q - 4'd1 ? 3'd0 : cnt_q + 3'd1;
      if (cnt_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      if (last) rk_valid_d = 1'b1;
    end
    rk_out_d = (rk_valid_q && rk_round <= nr_q) ?
               {w_q[{rk_round, 2'd0}], w_q[{rk_round, 2'd1}], w_q[{rk_round, 2'd2}], w_q[{rk_round, 2'd3}]} :
               128'h0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q <= 6'd0;
      cnt_q <= 3'd0;
      nk_q <= 4'd4;
      nr_q <= 4'd0;
      rcon_q <= 8'h01;
      err_q <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_out_q <= 128'h0;
    end else begin
      i_q <= i_d;
      cnt_q <= cnt_d;
      nk_q <= nk_d;
      nr_q <= nr_d;
      rcon_q <= rcon_d;
      err_q <= err_d;
      rk_valid_q <= rk_valid_d;
      rk_out_q <= rk_out_d;
    end
  end
  always_ff @(posedge clk) w_q <= w_d;
  assign err = err_q;
  assign rk_valid = rk_valid_q;
  assign rk_out = rk_out_q;
endmodule

module Sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  logic [10:0] idx;
  assign idx = {~in_byte, 3'b000};
  assign out_byte = TBL[idx +: 8];
endmodule

// File: tb/tb_key_schedule_gen.sv
// tb_key_schedule_gen: scoreboard bench; stimulus queues expected done latencies, err pulses and round-key reads,
// and a negedge monitor pops and compares them as the DUT presents each event.
module tb_key_schedule_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start2 = 1'b0;
  logic [1:0] key_len = 2'd0, key_len2 = 2'd0;
  logic [255:0] key = '0;
  logic [3:0] rk_round = 4'd0;
  logic busy, done, err, rk_valid, busy2, done2, err2, rk_valid2;
  logic [127:0] rk_out, rk_out2;
  logic rd_req = 1'b0, rd_q = 1'b0;
  int cyc = 0, acc_cyc = 0, checks = 0, errors = 0;
  logic [127:0] q_done[$], q_err[$], q_rd[$];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_schedule_gen u_dut (.clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .done(done), .err(err), .rk_valid(rk_valid), .rk_round(rk_round), .rk_out(rk_out));
  key_schedule_gen #(.SUPPORT_192(1), .SUPPORT_256(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .start(start2),
    .key_len(key_len2), .key(key), .busy(busy2), .done(done2), .err(err2), .rk_valid(rk_valid2),
    .rk_round(rk_round), .rk_out(rk_out2));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_q <= rd_req;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q_done.size() == 0) chk("done_unexpected", 128'(1), 128'(0));
      else chk("done_latency", 128'(cyc - acc_cyc), q_done.pop_front());
    end
    if (err) begin
      if (q_err.size() == 0) chk("err_unexpected", 128'(1), 128'(0));
      else chk("err_valid_busy", {126'h0, rk_valid, busy}, q_err.pop_front());
    end
    if (rd_q) begin
      if (q_rd.size() == 0) chk("rd_unexpected", 128'(1), 128'(0));
      else chk("rk_out", rk_out, q_rd.pop_front());
    end
  end

  task automatic go(input logic [1:0] len, input logic [255:0] k, input int lat);
    @(posedge clk); #1;
    key_len = len; key = k; start = 1'b1;
    if (lat > 0) q_done.push_back(128'(lat));
    @(posedge clk);
    acc_cyc = cyc;
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 100 && !done; n++) @(negedge clk);
    if (!done) chk("done_timeout", 128'(0), 128'(1));
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] r, input logic [127:0] exp);
    @(posedge clk); #1;
    rk_round = r; rd_req = 1'b1;
    q_rd.push_back(exp);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {123'h0, busy, done, err, rk_valid, |rk_out}, 128'h0);
    rst_n = 1'b1;
    go(2'd0, K128, 41);
    repeat (10) @(posedge clk);
    #1 key = K256; key_len = 2'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; key = K128;
    rd(4'd10, 128'h0);
    wait_done();
    rd(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(4'd11, 128'h0);
    go(2'd1, K192, 47);
    wait_done();
    rd(4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    rd(4'd12, 128'he98ba06f448c773c8ecc720401002202);
    rd(4'd13, 128'h0);
    go(2'd2, K256, 53);
    wait_done();
    rd(4'd1, 128'h1f352c073b6108d72d9810a30914dff4);
    rd(4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde);
    rd(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
    rd(4'd15, 128'h0);
    q_err.push_back(128'h0);
    go(2'd3, K256, 0);
    repeat (2) @(negedge clk);
    chk("err_idle_busy", 128'(busy), 128'(0));
    rd(4'd0, 128'h0);
    @(posedge clk); #1 key_len2 = 2'd2; start2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("err2_256_disabled", {126'h0, err2, busy2}, 128'h2);
    start2 = 1'b0;
    @(negedge clk);
    chk("err2_one_cycle", 128'(err2), 128'(0));
    go(2'd0, K128, 0);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("abort_state", {125'h0, busy, done, rk_valid}, 128'h0);
    repeat (60) @(posedge clk);
    #1 chk("abort_no_valid", 128'(rk_valid), 128'(0));
    go(2'd0, K128, 41);
    wait_done();
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    repeat (5) @(negedge clk);
    chk("pending_done", 128'(q_done.size()), 128'(0));
    chk("pending_err", 128'(q_err.size()), 128'(0));
    chk("pending_rd", 128'(q_rd.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
